in_service_controller: RTL and testbench
========================================

Name: in_service_controller

Overview:
- Downstream stage of the 8259 interrupt request register; consumes `interrupt_request_register` and produces the PIC interrupt output.
- Resolves priority among pending, unmasked requests, supporting fully nested and rotating priority modes.
- Runs the 8086-mode two-pulse INTA sequence: sets the in-service register (ISR), clears the serviced IRR bit, drives `freeze` back to the IRR, and emits the vector.
- Handles non-specific, specific and automatic EOI.

Parameters:
- NUM_IR, 8, number of interrupt levels; only 8 is supported, fixed by the 3-bit level encoding.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- interrupt_request_register  in  8  pending requests from the IRR stage
- interrupt_mask  in  8  IMR; 1 = level masked
- auto_eoi_config  in  1  1 = ISR bit cleared at the end of the second INTA
- rotate_on_aeoi  in  1  rotate priority on auto-EOI
- rotate_on_eoi  in  1  rotate priority on non-specific and specific EOI
- nonspecific_eoi  in  1  one-cycle strobe
- specific_eoi  in  1  one-cycle strobe; target level is `eoi_level`
- eoi_level  in  3  level for specific EOI
- set_priority  in  1  one-cycle strobe; loads lowest priority from `priority_level`
- priority_level  in  3  new lowest-priority level
- inta_pulse  in  1  one-cycle strobe per synchronised INTA falling edge
- vector_base  in  5  T7..T3 of the vector
- interrupt  out  1  registered INT to the CPU
- freeze  out  1  holds the IRR during an acknowledge sequence
- clear_interrupt_request  out  8  one-cycle one-hot clear to the IRR
- in_service_register  out  8  current ISR
- vector_out  out  8  vector = {vector_base, level}
- vector_valid  out  1  one-cycle strobe with `vector_out`

Behaviour:
- Reset values:
  - FSM = IDLE.
  - `in_service_register`, `clear_interrupt_request`, `vector_out` = 0.
  - `interrupt`, `freeze`, `vector_valid` = 0.
  - Lowest-priority register = 3'd7, so IR0 is highest priority.
- Priority:
  - Requests are `interrupt_request_register & ~interrupt_mask`.
  - Requests and ISR are rotated right by (lowest+1) mod 8, then find-first-set from bit 0.
  - A request level is eligible only if it has strictly higher priority than the highest set ISR bit (fully nested mode).
- `interrupt`:
  - Registered; asserts one cycle after an eligible request exists in IDLE.
  - Deasserts on entering ACK1.
  - Deasserts if the request disappears while still in IDLE.
- FSM states: IDLE, ACK1, ACK2.
  - IDLE -> ACK1 on `inta_pulse`, whether or not a request is eligible.
    - Eligible request: latch the winning level, set its ISR bit, pulse `clear_interrupt_request[level]` for one cycle.
    - No eligible request: latch level 7 as a spurious interrupt; ISR is not set and no clear pulse is issued.
    - `freeze` = 1 from ACK1 entry until the cycle after ACK2 completes.
  - ACK1 -> IDLE on the next `inta_pulse`.
    - `vector_out` = {vector_base, latched level}, `vector_valid` = 1 for exactly one cycle; `freeze` drops to 0.
    - If `auto_eoi_config` = 1 and the interrupt is not spurious, clear the ISR bit.
    - If `rotate_on_aeoi` is also set, lowest <= latched level.
    - ACK2 is the single transition cycle that carries these actions.
  - `inta_pulse` while ACK2 is in progress is ignored.
- EOI:
  - Non-specific EOI clears the highest-priority set ISR bit. If `rotate_on_eoi`, lowest <= that level. With ISR = 0 it has no effect.
  - Specific EOI clears `in_service_register[eoi_level]`. If `rotate_on_eoi`, lowest <= `eoi_level`.
- Simultaneous events:
  - EOI clears are evaluated on the pre-update ISR; the ACK1 set is applied afterwards, so a set of the same bit wins.
  - `set_priority` overrides any rotation in the same cycle.
  - Both EOI strobes in the same cycle: specific wins.
- Reset mid-sequence: FSM returns to IDLE, `freeze` drops immediately, no vector is emitted.

Optional Feature:
- Macro: SPECIAL_MASK_MODE_EN.
- Defined:
  - Adds input port `special_mask_mode` (1 bit).
  - When `special_mask_mode` = 1, nesting uses `in_service_register & ~interrupt_mask`, so masked in-service levels do not block lower levels.
- Undefined: the port is absent and nesting always uses the full ISR.

Decomposition:
- Package `pic_pkg`:
  - FSM state enum {IDLE, ACK1, ACK2}.
  - NUM_IR, LEVEL_W = 3, reset value of the lowest-priority register (3'd7).
  - Rotate-right function and one-hot-to-level function.
- Sub-module `priority_resolver`:
  - Combinational rotate + find-first-set, with a valid flag.
  - Instantiated twice: once for requests, once for the ISR.

Test Plan:
- IRR = 8'h24, IMR = 0, base = 5'h10; two `inta_pulse` -> `interrupt` = 1, ISR = 8'h04, clear = 8'h04 for one cycle, `vector_out` = 8'h82.
- ISR = 8'h04 with IRR = 8'h08 -> `interrupt` stays 0; IRR = 8'h01 -> `interrupt` = 1.
- IRR = 0 at the first INTA -> `vector_out` = {base, 3'd7}, ISR unchanged, no clear pulse.
- ISR = 8'h0A, `nonspecific_eoi` with `rotate_on_eoi` = 1 -> ISR = 8'h08, lowest = 1, so IR2 becomes highest priority.
- `auto_eoi_config` = 1, `rotate_on_aeoi` = 1, IRR = 8'h80 -> after the second INTA ISR = 0, lowest = 7, `vector_valid` pulses once.
- Reset asserted between the two INTA pulses -> `freeze` = 0, ISR = 0, `vector_valid` never asserts.

Source files
------------

// File: rtl/in_service_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared types, constants and helpers for the 8259 in-service
//               controller: FSM state encoding, level width, reset value of
//               the lowest-priority register, rotate-right and one-hot to
//               level conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    localparam int          NUM_IR     = 8;
    localparam int          LEVEL_W    = 3;
    localparam logic [2:0]  LOWEST_RST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    // Rotate an 8-bit vector right by n positions.
    function automatic logic [7:0] rotate_right(input logic [7:0] v,
                                                input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} >> n;
        return d[7:0];
    endfunction

    // Convert a one-hot (or zero) vector into its bit index.
    function automatic logic [2:0] onehot_to_level(input logic [7:0] oh);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) lvl = lvl | 3'(i);
        end
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_service_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : in_service_controller_if
// Description : Bus between the IRR stage / CPU-side control and the
//               in-service controller.
//   slave  modport : controller side (requests/control in, INT/vector out)
//   master modport : environment side
//   Optional       : SPECIAL_MASK_MODE_EN adds special_mask_mode
// Revision    : 1.0 - initial release
// ============================================================================
interface in_service_controller_if;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt_mask;
    logic       auto_eoi_config;
    logic       rotate_on_aeoi;
    logic       rotate_on_eoi;
    logic       nonspecific_eoi;
    logic       specific_eoi;
    logic [2:0] eoi_level;
    logic       set_priority;
    logic [2:0] priority_level;
    logic       inta_pulse;
    logic [4:0] vector_base;
`ifdef SPECIAL_MASK_MODE_EN
    logic       special_mask_mode;
`endif
    logic       interrupt;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] in_service_register;
    logic [7:0] vector_out;
    logic       vector_valid;

    modport slave (
        input  interrupt_request_register, interrupt_mask, auto_eoi_config,
               rotate_on_aeoi, rotate_on_eoi, nonspecific_eoi, specific_eoi,
               eoi_level, set_priority, priority_level, inta_pulse, vector_base,
`ifdef SPECIAL_MASK_MODE_EN
               special_mask_mode,
`endif
        output interrupt, freeze, clear_interrupt_request, in_service_register,
               vector_out, vector_valid
    );

    modport master (
        output interrupt_request_register, interrupt_mask, auto_eoi_config,
               rotate_on_aeoi, rotate_on_eoi, nonspecific_eoi, specific_eoi,
               eoi_level, set_priority, priority_level, inta_pulse, vector_base,
`ifdef SPECIAL_MASK_MODE_EN
               special_mask_mode,
`endif
        input  interrupt, freeze, clear_interrupt_request, in_service_register,
               vector_out, vector_valid
    );
endinterface
`default_nettype wire

// File: rtl/in_service_controller_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : priority_resolver
// Description : Combinational rotating find-first-set. The vector is rotated
//               right by (lowest+1) mod 8 so the highest-priority level lands
//               on bit 0; the first set bit gives the rank (0 = highest).
//   i_vec    : candidate levels
//   i_lowest : current lowest-priority level
//   o_valid  : any bit set
//   o_rank   : priority rank of the winner
//   o_level  : absolute level of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module priority_resolver
    import pic_pkg::*;
(
    input  wire logic [7:0] i_vec,
    input  wire logic [2:0] i_lowest,
    output logic            o_valid,
    output logic [2:0]      o_rank,
    output logic [2:0]      o_level
);
    logic [2:0] w_shift;
    logic [7:0] w_rot;
    logic [7:0] w_first;

    assign w_shift = i_lowest + 3'd1;
    assign w_rot   = rotate_right(i_vec, w_shift);
    // Isolate the least-significant set bit.
    assign w_first = w_rot & (~w_rot + 8'd1);
    assign o_valid = |w_rot;
    assign o_rank  = onehot_to_level(w_first);
    assign o_level = o_rank + w_shift;
endmodule
`default_nettype wire

// File: rtl/in_service_controller.sv
`default_nettype none
// ============================================================================
// Module      : in_service_controller
// Description : 8259 in-service stage. Resolves priority (fully nested,
//               rotating), runs the 8086 two-pulse INTA sequence, maintains
//               the ISR and handles non-specific, specific and automatic EOI.
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : requests, mask, EOI/priority control, INTA, vector base in;
//                  INT, freeze, IRR clear, ISR, vector and strobe out
//   Optional     : SPECIAL_MASK_MODE_EN - masked in-service levels do not
//                  block lower levels while special_mask_mode = 1
// Revision    : 1.0 - initial release
// ============================================================================
module in_service_controller
    import pic_pkg::*;
(
    input wire logic              clock,
    input wire logic              reset,
    in_service_controller_if.slave bus
);
    state_t     r_state, w_state_next;
    logic [7:0] r_isr, w_isr_next;
    logic [2:0] r_lowest, w_lowest_next;
    logic [2:0] r_level;
    logic       r_spurious;
    logic [7:0] r_clear;
    logic       r_interrupt;
    logic [7:0] r_vector_out;
    logic       r_vector_valid;

    logic [7:0] w_req;
    logic [7:0] w_isr_nest;
    logic       w_req_valid, w_isr_valid;
    logic [2:0] w_req_rank, w_isr_rank;
    logic [2:0] w_req_level, w_isr_level;
    logic       w_eligible;
    logic       w_ack_start, w_ack_end;

    assign w_req = bus.interrupt_request_register & ~bus.interrupt_mask;

`ifdef SPECIAL_MASK_MODE_EN
    assign w_isr_nest = bus.special_mask_mode ? (r_isr & ~bus.interrupt_mask) : r_isr;
`else
    assign w_isr_nest = r_isr;
`endif

    priority_resolver u_req_res (
        .i_vec    (w_req),
        .i_lowest (r_lowest),
        .o_valid  (w_req_valid),
        .o_rank   (w_req_rank),
        .o_level  (w_req_level)
    );

    priority_resolver u_isr_res (
        .i_vec    (w_isr_nest),
        .i_lowest (r_lowest),
        .o_valid  (w_isr_valid),
        .o_rank   (w_isr_rank),
        .o_level  (w_isr_level)
    );

    // Both ranks share the rotated frame, so a smaller rank is higher priority.
    assign w_eligible  = w_req_valid && (!w_isr_valid || (w_req_rank < w_isr_rank));
    assign w_ack_start = (r_state == IDLE) && bus.inta_pulse;
    assign w_ack_end   = (r_state == ACK1) && bus.inta_pulse;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.inta_pulse) w_state_next = ACK1;
            ACK1:    if (bus.inta_pulse) w_state_next = ACK2;
            ACK2:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ISR: EOI clears act on the current ISR, then AEOI clear, then the
    // acknowledge set, so a set of the same bit wins.
    always_comb begin
        w_isr_next = r_isr;
        if (bus.specific_eoi)
            w_isr_next[bus.eoi_level] = 1'b0;
        else if (bus.nonspecific_eoi && w_isr_valid)
            w_isr_next[w_isr_level] = 1'b0;
        if (w_ack_end && bus.auto_eoi_config && !r_spurious)
            w_isr_next[r_level] = 1'b0;
        if (w_ack_start && w_eligible)
            w_isr_next[w_req_level] = 1'b1;
    end

    // Lowest-priority register; an explicit set_priority beats any rotation.
    always_comb begin
        w_lowest_next = r_lowest;
        if (bus.rotate_on_eoi) begin
            if (bus.specific_eoi)
                w_lowest_next = bus.eoi_level;
            else if (bus.nonspecific_eoi && w_isr_valid)
                w_lowest_next = w_isr_level;
        end
        if (w_ack_end && bus.auto_eoi_config && bus.rotate_on_aeoi && !r_spurious)
            w_lowest_next = r_level;
        if (bus.set_priority)
            w_lowest_next = bus.priority_level;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_isr          <= 8'h00;
            r_lowest       <= LOWEST_RST;
            r_level        <= 3'd0;
            r_spurious     <= 1'b0;
            r_clear        <= 8'h00;
            r_interrupt    <= 1'b0;
            r_vector_out   <= 8'h00;
            r_vector_valid <= 1'b0;
        end else begin
            r_isr          <= w_isr_next;
            r_lowest       <= w_lowest_next;
            r_interrupt    <= (r_state == IDLE) && !bus.inta_pulse && w_eligible;
            r_clear        <= 8'h00;
            r_vector_valid <= 1'b0;
            if (w_ack_start) begin
                // With nothing eligible the acknowledge is spurious: IR7.
                r_level    <= w_eligible ? w_req_level : 3'd7;
                r_spurious <= !w_eligible;
                if (w_eligible) r_clear <= 8'h01 << w_req_level;
            end
            if (w_ack_end) begin
                r_vector_out   <= {bus.vector_base, r_level};
                r_vector_valid <= 1'b1;
            end
        end
    end

    // Derived straight from the state register so reset drops it at once.
    assign bus.freeze                  = (r_state != IDLE);
    assign bus.interrupt               = r_interrupt;
    assign bus.clear_interrupt_request = r_clear;
    assign bus.in_service_register     = r_isr;
    assign bus.vector_out              = r_vector_out;
    assign bus.vector_valid            = r_vector_valid;
endmodule
`default_nettype wire

// File: tb/tb_in_service_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_service_controller
// Description : Directed self-checking bench for in_service_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_in_service_controller;
    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;
    int   valid_seen;

    in_service_controller_if bus ();

    in_service_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic inta();
        bus.inta_pulse = 1'b1;
        tick();
        bus.inta_pulse = 1'b0;
    endtask

    task automatic spec_eoi(input logic [2:0] lvl);
        bus.eoi_level    = lvl;
        bus.specific_eoi = 1'b1;
        tick();
        bus.specific_eoi = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        bus.interrupt_request_register = 8'h00;
        bus.interrupt_mask  = 8'h00;
        bus.auto_eoi_config = 1'b0;
        bus.rotate_on_aeoi  = 1'b0;
        bus.rotate_on_eoi   = 1'b0;
        bus.nonspecific_eoi = 1'b0;
        bus.specific_eoi    = 1'b0;
        bus.eoi_level       = 3'd0;
        bus.set_priority    = 1'b0;
        bus.priority_level  = 3'd0;
        bus.inta_pulse      = 1'b0;
        bus.vector_base     = 5'h10;
`ifdef SPECIAL_MASK_MODE_EN
        bus.special_mask_mode = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_int",    {31'd0, bus.interrupt},    32'd0);
        chk("rst_isr",    {24'd0, bus.in_service_register}, 32'h00);
        chk("rst_freeze", {31'd0, bus.freeze},       32'd0);
        chk("rst_vout",   {24'd0, bus.vector_out},   32'h00);
        chk("rst_vvalid", {31'd0, bus.vector_valid}, 32'd0);
        chk("rst_clear",  {24'd0, bus.clear_interrupt_request}, 32'h00);

        // Basic acknowledge: IRR 24 -> IR2 wins, vector 82
        bus.interrupt_request_register = 8'h24;
        tick();
        chk("t1_int", {31'd0, bus.interrupt}, 32'd1);
        inta();
        chk("t1_isr",    {24'd0, bus.in_service_register}, 32'h04);
        chk("t1_clear",  {24'd0, bus.clear_interrupt_request}, 32'h04);
        chk("t1_freeze", {31'd0, bus.freeze}, 32'd1);
        chk("t1_int_ack", {31'd0, bus.interrupt}, 32'd0);
        bus.interrupt_request_register = 8'h20;
        tick();
        chk("t1_clear_1cyc", {24'd0, bus.clear_interrupt_request}, 32'h00);
        inta();
        chk("t1_vvalid", {31'd0, bus.vector_valid}, 32'd1);
        chk("t1_vout",   {24'd0, bus.vector_out},   32'h82);
        tick();
        chk("t1_vvalid_1cyc", {31'd0, bus.vector_valid}, 32'd0);
        chk("t1_freeze_off",  {31'd0, bus.freeze},       32'd0);

        // Nesting: ISR=04 blocks IR3 (and IR5), IR0 gets through
        bus.interrupt_request_register = 8'h08;
        tick();
        tick();
        chk("t2_nested_block", {31'd0, bus.interrupt}, 32'd0);
        bus.interrupt_request_register = 8'h01;
        tick();
        tick();
        chk("t2_nested_pass", {31'd0, bus.interrupt}, 32'd1);
        bus.interrupt_request_register = 8'h00;
        spec_eoi(3'd2);
        chk("t2_spec_eoi", {24'd0, bus.in_service_register}, 32'h00);
        tick();

        // Spurious acknowledge
        inta();
        chk("t3_isr",   {24'd0, bus.in_service_register}, 32'h00);
        chk("t3_clear", {24'd0, bus.clear_interrupt_request}, 32'h00);
        inta();
        chk("t3_vout",   {24'd0, bus.vector_out},   32'h87);
        chk("t3_vvalid", {31'd0, bus.vector_valid}, 32'd1);
        tick();

        // Build ISR=0A, then rotating non-specific EOI
        bus.interrupt_request_register = 8'h08;
        tick();
        inta();
        bus.interrupt_request_register = 8'h00;
        inta();
        tick();
        bus.interrupt_request_register = 8'h02;
        tick();
        inta();
        bus.interrupt_request_register = 8'h00;
        inta();
        tick();
        chk("t4_isr_0a", {24'd0, bus.in_service_register}, 32'h0A);
        bus.rotate_on_eoi   = 1'b1;
        bus.nonspecific_eoi = 1'b1;
        tick();
        bus.nonspecific_eoi = 1'b0;
        bus.rotate_on_eoi   = 1'b0;
        chk("t4_ns_eoi", {24'd0, bus.in_service_register}, 32'h08);
        // lowest=1: IR0/IR1 now rank below in-service IR3
        bus.interrupt_request_register = 8'h03;
        tick();
        tick();
        chk("t4_rot_block", {31'd0, bus.interrupt}, 32'd0);
        bus.interrupt_request_register = 8'h04;
        tick();
        tick();
        chk("t4_rot_ir2", {31'd0, bus.interrupt}, 32'd1);
        spec_eoi(3'd3);
        bus.interrupt_request_register = 8'h05;
        tick();
        inta();
        chk("t4_ir2_wins", {24'd0, bus.in_service_register}, 32'h04);
        bus.interrupt_request_register = 8'h01;
        inta();
        chk("t4_vout", {24'd0, bus.vector_out}, 32'h82);
        bus.interrupt_request_register = 8'h00;
        tick();
        spec_eoi(3'd2);
        bus.priority_level = 3'd7;
        bus.set_priority   = 1'b1;
        tick();
        bus.set_priority   = 1'b0;

        // Automatic EOI with rotation
        bus.auto_eoi_config = 1'b1;
        bus.rotate_on_aeoi  = 1'b1;
        bus.interrupt_request_register = 8'h80;
        tick();
        chk("t5_int", {31'd0, bus.interrupt}, 32'd1);
        inta();
        chk("t5_isr_set", {24'd0, bus.in_service_register}, 32'h80);
        bus.interrupt_request_register = 8'h00;
        inta();
        chk("t5_isr_aeoi", {24'd0, bus.in_service_register}, 32'h00);
        chk("t5_vvalid",   {31'd0, bus.vector_valid}, 32'd1);
        chk("t5_vout",     {24'd0, bus.vector_out},   32'h87);
        tick();
        chk("t5_vvalid_once", {31'd0, bus.vector_valid}, 32'd0);
        // lowest still 7: IR0 beats IR7
        bus.interrupt_request_register = 8'h81;
        tick();
        inta();
        bus.interrupt_request_register = 8'h80;
        inta();
        chk("t5_ir0_first", {24'd0, bus.vector_out}, 32'h80);
        tick();
        // AEOI rotation made IR0 lowest: IR1 beats IR0 and IR7
        bus.interrupt_request_register = 8'h83;
        tick();
        inta();
        bus.interrupt_request_register = 8'h81;
        inta();
        chk("t5_rot_ir1", {24'd0, bus.vector_out}, 32'h81);
        bus.interrupt_request_register = 8'h00;
        bus.auto_eoi_config = 1'b0;
        bus.rotate_on_aeoi  = 1'b0;
        bus.priority_level  = 3'd7;
        bus.set_priority    = 1'b1;
        tick();
        bus.set_priority    = 1'b0;
        tick();

        // Reset between the two INTA pulses
        bus.interrupt_request_register = 8'h01;
        tick();
        inta();
        chk("t6_freeze_on", {31'd0, bus.freeze}, 32'd1);
        bus.interrupt_request_register = 8'h00;
        reset = 1'b1;
        #1;
        chk("t6_freeze_async", {31'd0, bus.freeze}, 32'd0);
        chk("t6_isr_async",    {24'd0, bus.in_service_register}, 32'h00);
        tick();
        reset = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.vector_valid) valid_seen++;
        end
        chk("t6_no_vector", valid_seen, 32'd0);
        chk("t6_freeze_off", {31'd0, bus.freeze}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
